// File: rtl/keys_pkg.sv
// Shared sizing helpers and the event packing layout for the key debouncer.
// An event is packed as {idx, make}, with make in bit 0.
package keys_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int idx_w(input int keys);
    return (keys <= 1) ? 1 : clog2(keys);
  endfunction

  function automatic int cnt_w(input int dc);
    return clog2(dc + 1);
  endfunction

  function automatic int lvl_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int evt_w(input int keys);
    return idx_w(keys) + 1;
  endfunction

  function automatic bit params_ok(input int keys, input int dc, input int ss, input int depth);
    return (keys >= 1) && (keys <= 256) && (dc >= 1) && (ss >= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/keys_debounce_evt_if.sv
// Key-change event stream: FWFT head with valid/ready, plus the queue occupancy.
interface keys_debounce_evt_if import keys_pkg::*; #(
  parameter int KEYS       = 61,
  parameter int FIFO_DEPTH = 8
);
  localparam int IDX_W = idx_w(KEYS);
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [IDX_W-1:0] evt_key_o;
  logic             evt_make_o;
  logic [LVL_W-1:0] evt_level_o;

  modport master (output evt_valid_o, evt_key_o, evt_make_o, evt_level_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_key_o, evt_make_o, evt_level_o, output evt_ready_i);
endinterface

// File: rtl/keys_evt_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is taken only when a pop frees the slot.
module keys_evt_fifo import keys_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/keys_debounce_evt.sv
// Synchronise and integrate raw key switches, emit press/release strobes and
// a lowest-index-first queue of key-change events for the host report logic.
module keys_debounce_evt import keys_pkg::*; #(
  parameter int KEYS            = 61,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [KEYS-1:0] keys_i,
  output logic [KEYS-1:0] keys_o,
  output logic [KEYS-1:0] press_o,
  output logic [KEYS-1:0] release_o,
  keys_debounce_evt_if.master evt
);
  localparam int IDX_W = idx_w(KEYS);
  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int EVT_W = evt_w(KEYS);
  localparam int LVL_W = lvl_w(FIFO_DEPTH);

  if (!params_ok(KEYS, DEBOUNCE_CYCLES, SYNC_STAGES, FIFO_DEPTH)) begin : g_bad_params
    $error("keys_debounce_evt: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0][KEYS-1:0] sync_q;
  logic [KEYS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [KEYS-1:0]                  keys_q, keys_d, keys_dly_q, press_q, release_q;
  logic [KEYS-1:0]                  rep_q, rep_d, pend, s;
  logic [IDX_W-1:0]                 sel_idx;
  logic                             sel_vld, push, pop, full, empty;
  logic [EVT_W-1:0]                 head;
  logic [LVL_W-1:0]                 level;

  assign s = sync_q[SYNC_STAGES-1];

  // Any sample that agrees with the current level restarts the integration.
  always_comb begin
    cnt_d  = cnt_q;
    keys_d = keys_q;
    for (int k = 0; k < KEYS; k++) begin
      if (s[k] == keys_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        keys_d[k] = s[k];
        cnt_d[k]  = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // rep tracks what the host has been told; a key that bounces back clears its pend bit.
  assign pend = keys_q ^ rep_q;

  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_idx = IDX_W'(k);
        sel_vld = 1'b1;
      end
    end
  end

  assign pop  = ~empty & evt.evt_ready_i;
  assign push = sel_vld & (~full | pop);

  always_comb begin
    rep_d = rep_q;
    if (push) rep_d[sel_idx] = keys_q[sel_idx];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      keys_q     <= '0;
      keys_dly_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      rep_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], keys_i};
      cnt_q      <= cnt_d;
      keys_q     <= keys_d;
      keys_dly_q <= keys_q;
      press_q    <= keys_q & ~keys_dly_q;
      release_q  <= ~keys_q & keys_dly_q;
      rep_q      <= rep_d;
    end
  end

  keys_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .din_i   ({sel_idx, keys_q[sel_idx]}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign keys_o          = keys_q;
  assign press_o         = press_q;
  assign release_o       = release_q;
  assign evt.evt_valid_o = ~empty;
  assign evt.evt_key_o   = head[EVT_W-1:1];
  assign evt.evt_make_o  = head[0];
  assign evt.evt_level_o = level;
endmodule

// File: tb/tb_keys_debounce_evt.sv
// Randomised and directed bench for keys_debounce_evt against a window-based reference model.
module tb_keys_debounce_evt;
  localparam int KEYS = 61;
  localparam int DC   = 4;
  localparam int SS   = 2;
  localparam int FD   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [KEYS-1:0] keys_i = '0;
  logic [KEYS-1:0] keys_o, press_o, release_o;

  keys_debounce_evt_if #(.KEYS(KEYS), .FIFO_DEPTH(FD)) evt_if ();

  keys_debounce_evt #(.KEYS(KEYS), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .keys_i    (keys_i),
    .keys_o    (keys_o),
    .press_o   (press_o),
    .release_o (release_o),
    .evt       (evt_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key's level flips once the last DC synchronised samples
  // (raw samples SS..SS+DC-1 edges back) all disagree with it.
  bit [KEYS-1:0] mdeb, mdeb_prev, mrep, mpress, mrel, mpend, mflip;
  bit [KEYS-1:0] hist[$];
  int            occ;
  int            sb[$];
  int            midx;
  bit            mpop, mpush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdeb = '0; mdeb_prev = '0; mrep = '0; mpress = '0; mrel = '0;
      hist.delete();
      for (int j = 0; j < SS + DC; j++) hist.push_back('0);
      occ = 0;
      sb.delete();
    end else begin
      mpop  = (occ > 0) && evt_if.evt_ready_i;
      mpend = mdeb ^ mrep;
      midx  = -1;
      for (int k = 0; k < KEYS; k++) if (mpend[k] && midx < 0) midx = k;
      mpush = (midx >= 0) && ((occ < FD) || mpop);
      if (mpush) begin
        sb.push_back(midx * 2 + int'(mdeb[midx]));
        mrep[midx] = mdeb[midx];
      end
      occ = occ + int'(mpush) - int'(mpop);
      mpress = mdeb & ~mdeb_prev;
      mrel   = ~mdeb & mdeb_prev;
      hist.push_front(keys_i);
      void'(hist.pop_back());
      mflip = '1;
      for (int j = SS; j < SS + DC; j++) mflip &= hist[j] ^ mdeb;
      mdeb_prev = mdeb;
      mdeb      = mdeb ^ mflip;
    end
  end

  // Monitor: compares levels every cycle and each accepted event against the scoreboard.
  int exp_evt;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("keys_o", 64'(keys_o), 64'(mdeb));
      chk("press_o", 64'(press_o), 64'(mpress));
      chk("release_o", 64'(release_o), 64'(mrel));
      chk("evt_level", 64'(evt_if.evt_level_o), 64'(occ));
      chk("evt_valid", 64'(evt_if.evt_valid_o), 64'(occ > 0));
      if (evt_if.evt_valid_o && evt_if.evt_ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL evt_unexpected: got key %0d make %0d expected no event at %0t",
                   evt_if.evt_key_o, evt_if.evt_make_o, $time);
        end else begin
          exp_evt = sb.pop_front();
          chk("evt_key", 64'(evt_if.evt_key_o), 64'(exp_evt / 2));
          chk("evt_make", 64'(evt_if.evt_make_o), 64'(exp_evt % 2));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_keys"}, 64'(keys_o), 64'd0);
    chk({tag, "_press"}, 64'(press_o), 64'd0);
    chk({tag, "_release"}, 64'(release_o), 64'd0);
    chk({tag, "_valid"}, 64'(evt_if.evt_valid_o), 64'd0);
    chk({tag, "_level"}, 64'(evt_if.evt_level_o), 64'd0);
  endtask

  initial begin
    evt_if.evt_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Clean press and release
    evt_if.evt_ready_i = 1'b1;
    keys_i[5] = 1'b1; cyc(12);
    keys_i[5] = 1'b0; cyc(12);

    // Bounce shorter than the debounce window
    keys_i[7] = 1'b1; cyc(3);
    keys_i[7] = 1'b0; cyc(1);
    keys_i[7] = 1'b1; cyc(3);
    keys_i[7] = 1'b0; cyc(12);

    // Simultaneous changes, drained in index order
    keys_i[3] = 1'b1; keys_i[10] = 1'b1; keys_i[60] = 1'b1; cyc(15);
    keys_i[3] = 1'b0; keys_i[10] = 1'b0; keys_i[60] = 1'b0; cyc(15);

    // Backpressure: FIFO saturates, the rest stays pending
    evt_if.evt_ready_i = 1'b0;
    keys_i[5:0] = 6'h3f; cyc(15);
    chk("bp_level_full", 64'(evt_if.evt_level_o), 64'd4);
    evt_if.evt_ready_i = 1'b1; cyc(12);

    // Coalescing while the FIFO is full
    evt_if.evt_ready_i = 1'b0;
    keys_i[5:0] = 6'h00; cyc(12);
    keys_i[20] = 1'b1; cyc(8);
    keys_i[20] = 1'b0; cyc(10);
    evt_if.evt_ready_i = 1'b1; cyc(15);

    // Asynchronous reset with queued events and a count in flight
    evt_if.evt_ready_i = 1'b0;
    keys_i[30] = 1'b1; keys_i[31] = 1'b1; keys_i[32] = 1'b1; cyc(10);
    chk("pre_reset_level", 64'(evt_if.evt_level_o), 64'd3);
    keys_i[40] = 1'b1; cyc(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    keys_i = '0;
    cyc(2);
    rst_n = 1'b1;
    evt_if.evt_ready_i = 1'b1;
    cyc(20);
    chk("post_reset_level", 64'(evt_if.evt_level_o), 64'd0);

    // Random key activity on a small key subset plus random backpressure
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) keys_i[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) keys_i[$urandom_range(16, 60)] ^= 1'b1;
      evt_if.evt_ready_i = ($urandom_range(0, 3) != 0);
      cyc(1);
    end

    keys_i = '0;
    evt_if.evt_ready_i = 1'b1;
    cyc(80);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
